// File: rtl/game_pkg.sv
// Shared game-state codes, screen geometry and the platform manager state type.
package game_pkg;

  localparam logic [2:0] GS_MAIN    = 3'b000;
  localparam logic [2:0] GS_LOAD    = 3'b001;
  localparam logic [2:0] GS_GAME    = 3'b010;
  localparam logic [2:0] GS_PAUSE   = 3'b011;
  localparam logic [2:0] GS_REFRESH = 3'b100;
  localparam logic [2:0] GS_INIT    = 3'b101;
  localparam logic [2:0] GS_OVER    = 3'b110;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_SCROLL,
    ST_DONE
  } scroll_state_t;

endpackage

// File: rtl/plat_lfsr.sv
// Free-running 16-bit Galois LFSR that supplies a folded platform X coordinate.
module plat_lfsr #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic [15:0] TAPS    = 16'hB400,
  parameter int          X_LIMIT = 576
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       en,
  output logic [9:0] x
);

  localparam logic [9:0] LIMIT = 10'(X_LIMIT);

  logic [15:0] lfsr;

  // Shift right; when the bit leaving is set, fold the taps back in.
  always_ff @(posedge Clock) begin
    if (Reset)
      lfsr <= SEED;
    else if (en)
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  end

  // A single subtract covers the whole 10-bit range since 1023 < 2*LIMIT.
  always_comb begin
    x = (lfsr[9:0] >= LIMIT) ? (lfsr[9:0] - LIMIT) : lfsr[9:0];
  end

endmodule

// File: rtl/plat_scroll_ctrl.sv
// Platform field manager: initial load, refresh request, scroll and regeneration.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for loadplat or the Game state
// ST_LOAD   | writing one initial platform per Clock
// ST_ARMED  | in play; refresh_en tracks the climb threshold
// ST_SCROLL | moving platforms down SCROLL_STEP per frame until done
// ST_DONE   | one-cycle trigger back to the game FSM
module plat_scroll_ctrl
  import game_pkg::*;
#(
  parameter int NUM_PLAT    = 8,
  parameter int SCREEN_W    = game_pkg::SCREEN_W,
  parameter int SCREEN_H    = game_pkg::SCREEN_H,
  parameter int PLAT_W      = 64,
  parameter int SPACING     = 60,
  parameter int TRIGGER_Y   = 160,
  parameter int SCROLL_STEP = 4,
  parameter int MAX_SCROLL  = 120
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic [2:0]            outstate,
  input  logic                  loadplat,
  input  logic [9:0]            doodle_y,
  input  logic                  doodle_falling,
  output logic                  refresh_en,
  output logic                  trigger,
  output logic [NUM_PLAT*10-1:0] plat_x_flat,
  output logic [NUM_PLAT*10-1:0] plat_y_flat,
  output logic [15:0]           plat_passed
);

  localparam int         IDX_W  = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam logic [9:0] TRIG_Y = 10'(TRIGGER_Y);
  localparam logic [9:0] STEP   = 10'(SCROLL_STEP);
  localparam logic [9:0] MAXS   = 10'(MAX_SCROLL);
  localparam logic [10:0] H11   = 11'(SCREEN_H);

  scroll_state_t       state;
  logic [IDX_W-1:0]    idx;
  logic [9:0]          remaining;
  logic [9:0]          plat_x [NUM_PLAT];
  logic [9:0]          plat_y [NUM_PLAT];
  logic                fc_s1, fc_s2, fc_s3, frame_tick;
  logic [9:0]          lfsr_x;

  logic [9:0]          step;
  logic [9:0]          entry_rem;
  logic [9:0]          climb;
  logic [10:0]         sum_y  [NUM_PLAT];
  logic [9:0]          next_y [NUM_PLAT];
  logic                regen  [NUM_PLAT];
  logic [16:0]         passed_sum;
  logic [15:0]         passed_next;

  plat_lfsr #(
    .SEED    (16'hACE1),
    .TAPS    (16'hB400),
    .X_LIMIT (SCREEN_W - PLAT_W)
  ) u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .en    (1'b1),
    .x     (lfsr_x)
  );

  function automatic logic [9:0] load_y(input logic [IDX_W-1:0] i);
    return 10'(SCREEN_H - 20 - int'(i) * SPACING);
  endfunction

  // Bring frame_clk into the Clock domain and register a rising-edge pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fc_s1      <= 1'b0;
      fc_s2      <= 1'b0;
      fc_s3      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      fc_s1      <= frame_clk;
      fc_s2      <= fc_s1;
      fc_s3      <= fc_s2;
      frame_tick <= fc_s2 & ~fc_s3;
    end
  end

  // Scroll arithmetic: step size, per-platform wrap and saturating pass count.
  always_comb begin
    step       = (remaining < STEP) ? remaining : STEP;
    climb      = TRIG_Y - doodle_y;
    entry_rem  = (doodle_y >= TRIG_Y) ? STEP : ((climb > MAXS) ? MAXS : climb);
    passed_sum = {1'b0, plat_passed};
    for (int i = 0; i < NUM_PLAT; i++) begin
      sum_y[i]  = {1'b0, plat_y[i]} + {1'b0, step};
      regen[i]  = (sum_y[i] >= H11);
      next_y[i] = regen[i] ? 10'(sum_y[i] - H11) : sum_y[i][9:0];
      passed_sum = passed_sum + 17'(regen[i]);
    end
    passed_next = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];
  end

  // Main controller FSM with registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      remaining   <= '0;
      refresh_en  <= 1'b0;
      trigger     <= 1'b0;
      plat_passed <= '0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        plat_x[i] <= '0;
        plat_y[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          refresh_en <= 1'b0;
          trigger    <= 1'b0;
          if (loadplat) begin
            idx         <= '0;
            plat_passed <= '0;
            state       <= ST_LOAD;
          end else if (outstate == GS_GAME) begin
            state <= ST_ARMED;
          end
        end
        ST_LOAD: begin
          if (!loadplat) begin
            state <= ST_IDLE;
          end else begin
            plat_y[idx] <= load_y(idx);
            plat_x[idx] <= lfsr_x;
            if (idx == IDX_W'(NUM_PLAT - 1))
              state <= ST_IDLE;
            else
              idx <= idx + 1'b1;
          end
        end
        ST_ARMED: begin
          if (outstate == GS_REFRESH) begin
            remaining  <= entry_rem;
            refresh_en <= 1'b0;
            state      <= ST_SCROLL;
          end else if (outstate == GS_MAIN || outstate == GS_OVER || outstate == GS_INIT) begin
            refresh_en <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            refresh_en <= (outstate == GS_GAME) && (doodle_y < TRIG_Y) && !doodle_falling;
          end
        end
        ST_SCROLL: begin
          // Leaving Refreshing early abandons the scroll where it stands.
          if (outstate != GS_REFRESH) begin
            state <= ST_IDLE;
          end else if (frame_tick) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
              plat_y[i] <= next_y[i];
              if (regen[i])
                plat_x[i] <= lfsr_x;
            end
            plat_passed <= passed_next;
            remaining   <= remaining - step;
            if (remaining == step) begin
              trigger <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          trigger <= 1'b0;
          state   <= ST_ARMED;
        end
        default: begin
          trigger    <= 1'b0;
          refresh_en <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_flat
    assign plat_x_flat[10*g +: 10] = plat_x[g];
    assign plat_y_flat[10*g +: 10] = plat_y[g];
  end

endmodule

// File: doc/plat_scroll_ctrl.md
Name: plat_scroll_ctrl

Overview:
- Platform field manager that sits directly downstream of the game-state FSM.
- Consumes the FSM's 3-bit game-state code, `loadplat` and `frame_clk`.
- Owns the Y/X positions of all platforms: loads the initial field, requests screen refresh (`refresh_en`) when the doodle climbs past a threshold, and scrolls/regenerates platforms during the Refreshing state.
- Returns a one-cycle `trigger` to the FSM when the scroll completes.

Parameters:
- NUM_PLAT, 8, number of platforms
- SCREEN_W, 640, screen width in pixels
- SCREEN_H, 480, screen height in pixels
- PLAT_W, 64, platform width in pixels
- SPACING, 60, initial vertical gap between platforms
- TRIGGER_Y, 160, doodle Y above which a refresh is requested
- SCROLL_STEP, 4, pixels scrolled per frame
- MAX_SCROLL, 120, clamp on scroll amount per refresh

Ports:
- Clock, in, 1, system clock
- Reset, in, 1, synchronous active-high reset
- frame_clk, in, 1, frame strobe; sampled in the Clock domain
- outstate, in, 3, game state code: 000 Main_Menu, 001 Loading, 010 Game, 011 Pause, 100 Refreshing, 101 INIT, 110 Game_Over
- loadplat, in, 1, load initial platform field
- doodle_y, in, 10, doodle top Y (0 = top of screen)
- doodle_falling, in, 1, doodle vertical velocity is downward
- refresh_en, out, 1, request Game->Refreshing
- trigger, out, 1, one-cycle pulse: scroll complete
- plat_x_flat, out, NUM_PLAT*10, platform X positions; platform i at bits [10i+9:10i]
- plat_y_flat, out, NUM_PLAT*10, platform Y positions, same packing
- plat_passed, out, 16, platforms regenerated since last load; saturates at FFFF

Behaviour:
- Reset values: state IDLE; all plat_x = 0 and plat_y = 0; refresh_en = 0; trigger = 0; plat_passed = 0; LFSR = 16'hACE1.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser plus a rising-edge detector.
  - `frame_tick` is a 1-Clock pulse, lagging the frame_clk edge by 3 cycles.
- LFSR:
  - 16-bit Galois, taps 16'hB400; advances every Clock cycle, including in IDLE.
  - New X = lfsr[9:0]; if ≥ SCREEN_W−PLAT_W (576), subtract 576. One subtract is sufficient because 1023 < 1152.
- State machine (states IDLE, LOAD, ARMED, SCROLL, DONE):
  - IDLE:
    - loadplat=1 → LOAD, with index=0 and plat_passed cleared.
    - outstate=010 → ARMED.
  - LOAD:
    - One platform per Clock: plat_y[i] = SCREEN_H−20−i·SPACING; plat_x[i] = LFSR X.
    - After i = NUM_PLAT−1 → IDLE.
    - loadplat falling mid-load aborts to IDLE. Loaded entries are kept; the rest are unchanged.
  - ARMED:
    - refresh_en is registered: 1 iff outstate=010 && doodle_y < TRIGGER_Y && !doodle_falling; otherwise 0.
    - On outstate=100: latch remaining = min(TRIGGER_Y−doodle_y, MAX_SCROLL), computed 10-bit unsigned. If doodle_y ≥ TRIGGER_Y, remaining = SCROLL_STEP. Clear refresh_en, go to SCROLL.
    - outstate ∈ {000,110,101} → IDLE.
  - SCROLL:
    - On each frame_tick: step = min(SCROLL_STEP, remaining). Every plat_y += step in an 11-bit sum; remaining −= step.
    - If sum ≥ SCREEN_H, that platform is regenerated: plat_y = sum−SCREEN_H, plat_x = LFSR X, plat_passed += 1 (saturating).
    - Multiple platforms regenerating in one tick all take the same LFSR X value. This is accepted.
    - remaining==0 after an update → DONE.
    - outstate ≠ 100 mid-scroll (e.g. Reset of the FSM, return to menu) → IDLE. trigger is never pulsed; positions keep their partial scroll.
  - DONE: trigger=1 for exactly one Clock, then → ARMED. trigger is 0 in every other state and cycle.
- Pause (011) in ARMED: refresh_en=0, state held.
- frame_tick in any state other than SCROLL is ignored.
- Reset mid-operation returns to the reset values on the next Clock edge, including the LFSR.

Decomposition:
- Shared package game_pkg:
  - Game-state codes GS_MAIN=3'b000, GS_LOAD=3'b001, GS_GAME=3'b010, GS_PAUSE=3'b011, GS_REFRESH=3'b100, GS_INIT=3'b101, GS_OVER=3'b110.
  - Screen constants SCREEN_W and SCREEN_H.
- Sub-module plat_lfsr: 16-bit Galois LFSR with seed, enable and a 10-bit X output with the range fold.

Test Plan:
- Reset → all outputs 0. Then loadplat=1 for 10 cycles → plat_y[0]=460, plat_y[7]=40, every plat_x < 576, plat_passed=0.
- outstate=010, doodle_y=100, doodle_falling=0 → refresh_en=1 one cycle later. Set doodle_falling=1 → refresh_en=0 next cycle.
- outstate=100 with doodle_y=100 (remaining=60), then 15 frame_tick pulses:
  - trigger pulses once, 1 cycle after the 15th tick.
  - plat_y[0]: 460→520 wraps to 40; plat_passed=1; plat_y[7]=100.
- doodle_y=0 at refresh entry → remaining clamps to 120; trigger after exactly 30 ticks.
- Mid-scroll (after 5 ticks) outstate→000 → no trigger; plat_y[7]=60; state IDLE; a 6th tick changes nothing.
- Reset asserted during SCROLL → next cycle all positions 0, trigger=0, LFSR=ACE1. The first LFSR X after reset matches the golden model.
